// File: rtl/funkcja_tester_pkg.sv
// Shared definitions for the function-tester sweep sequencer.
// Holds the state encoding and the legal settle-time range.
package funkcja_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tester_state_t;

    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/tester_settle_cnt.sv
// Loadable down-counter with terminal-count flag for lab sequencers.
// Latency: load/decrement visible one cycle later; tc is combinational from the count register.
// Backpressure: none; the owner holds dec low to freeze the count.
import funkcja_tester_pkg::*;

module tester_settle_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          tc
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/funkcja_tester.sv
// Exhaustive truth-table sweeper and checker for a small combinational block.
// Latency: 2**N_IN * (SETTLE_CYCLES+1) cycles from start to the one-cycle done pulse.
// Backpressure: none; start is ignored while busy or in DONE, abort cancels without results.
import funkcja_tester_pkg::*;

module funkcja_tester #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   expected,
    input  logic                   f_out,
    output logic [N_IN-1:0]        f_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        first_err
);

    localparam int W = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    generate
        if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
            $error("funkcja_tester: SETTLE_CYCLES out of range 1..15");
        end
    endgenerate

    tester_state_t   state;
    logic [N_IN-1:0] idx;
    logic [W-1:0]    exp_q;
    logic [W-1:0]    shadow;
    logic [N_IN:0]   err_acc;
    logic [N_IN-1:0] first_acc;

    logic            mismatch;
    logic [W-1:0]    shadow_nxt;
    logic [N_IN:0]   err_nxt;
    logic [N_IN-1:0] first_nxt;
    logic            go;
    logic            cnt_load;
    logic            cnt_dec;
    logic            settled;

    assign go = (state == ST_IDLE) && start && !abort;

    // Reload the settle time when a sweep begins and whenever we advance to the next vector.
    assign cnt_load = go || ((state == ST_SAMPLE) && !abort && (idx != LAST_IDX));
    assign cnt_dec  = (state == ST_SETTLE) && !abort;

    tester_settle_cnt #(
        .CW (CNT_W)
    ) u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .dec      (cnt_dec),
        .tc       (settled)
    );

    // Next-value view of the accumulators so the final vector lands in the published results.
    always_comb begin
        mismatch        = (f_out != exp_q[idx]);
        shadow_nxt      = shadow;
        shadow_nxt[idx] = f_out;
        err_nxt         = err_acc + {{N_IN{1'b0}}, mismatch};
        first_nxt       = (mismatch && err_acc == '0) ? idx : first_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            exp_q     <= '0;
            shadow    <= '0;
            err_acc   <= '0;
            first_acc <= '0;
            f_in      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            table_out <= '0;
            err_count <= '0;
            first_err <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    f_in <= '0;
                    busy <= 1'b0;
                    if (go) begin
                        state     <= ST_SETTLE;
                        idx       <= '0;
                        exp_q     <= expected;
                        shadow    <= '0;
                        err_acc   <= '0;
                        first_acc <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        f_in  <= '0;
                        busy  <= 1'b0;
                    end else if (settled) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        f_in  <= '0;
                        busy  <= 1'b0;
                    end else begin
                        shadow    <= shadow_nxt;
                        err_acc   <= err_nxt;
                        first_acc <= first_nxt;
                        if (idx == LAST_IDX) begin
                            state     <= ST_DONE;
                            f_in      <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            table_out <= shadow_nxt;
                            err_count <= err_nxt;
                            first_err <= first_nxt;
                            pass      <= (err_nxt == '0);
                        end else begin
                            state <= ST_SETTLE;
                            idx   <= idx + 1'b1;
                            f_in  <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
